prbs_chk: RTL and testbench

Receive-side checker for the 8-bit Fibonacci PRBS/M-sequence generator (default polynomial x^8+x^4+x^3+x^2+1). Sits directly downstream of the generator's serial `m_seq` output, or of the channel carrying it. It self-synchronises a local LFSR to the incoming bit stream, declares lock, then counts bit errors and drops lock on excessive error density.

---
 rtl/prbs_chk.sv | 129 ++++++++++++
 tb/tb_prbs_chk.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_chk.sv
// Self-synchronising receive checker for a Fibonacci PRBS stream: seed, verify, lock, count errors.
// Define PRBS_CHK_BITCNT_EN to build the 32-bit compared-bit counter (bit_cnt); otherwise it is tied to 0.
module prbs_chk #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] POLY       = 8'b10001110,
   parameter int               LOCK_CNT   = 16,
   parameter int               WIN        = 64,
   parameter int               UNLOCK_ERR = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_bit,
   input  logic        clr,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_cnt,
   output logic [31:0] bit_cnt
);

   typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

   localparam logic [7:0]  FILL_LAST = 8'(WIDTH - 1);
   localparam logic [7:0]  RUN_LAST  = 8'(LOCK_CNT - 1);
   localparam logic [15:0] WIN_LAST  = 16'(WIN - 1);
   localparam logic [15:0] ERR_LAST  = 16'(UNLOCK_ERR - 1);

   state_t           state;
   logic [WIDTH-1:0] c;
   logic [7:0]       fill;
   logic [7:0]       run;
   logic [15:0]      win_cnt;
   logic [15:0]      win_err;
   logic             p;
   logic             mismatch;

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      p = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         p = p ^ (c[k] & POLY[WIDTH-1-k]);
      end
   end

   assign mismatch = in_bit ^ p;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEED;
         c         <= '0;
         fill      <= '0;
         run       <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_cnt   <= '0;
      end else begin
         err_pulse <= 1'b0;
         if (clr) err_cnt <= '0;
         if (in_valid) begin
            // Once locked the shadow register free-runs on its own prediction, so line errors do not propagate.
            c <= {(state == LOCKED) ? p : in_bit, c[WIDTH-1:1]};
            case (state)
               SEED: begin
                  if (fill == FILL_LAST) begin
                     state <= VERIFY;
                     fill  <= '0;
                     run   <= '0;
                  end else begin
                     fill <= fill + 8'd1;
                  end
               end
               VERIFY: begin
                  if (mismatch || c == '0) begin
                     state <= SEED;
                     fill  <= '0;
                  end else if (run == RUN_LAST) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                     run    <= '0;
                  end else begin
                     run <= run + 8'd1;
                  end
               end
               LOCKED: begin
                  if (mismatch) begin
                     err_pulse <= 1'b1;
                     if (!clr && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                  end
                  // Loss of lock wins over the window wrap on the same bit.
                  if (mismatch && win_err == ERR_LAST) begin
                     state   <= SEED;
                     locked  <= 1'b0;
                     fill    <= '0;
                     win_cnt <= '0;
                     win_err <= '0;
                  end else if (win_cnt == WIN_LAST) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     win_cnt <= win_cnt + 16'd1;
                     if (mismatch) win_err <= win_err + 16'd1;
                  end
               end
               default: begin
                  state  <= SEED;
                  locked <= 1'b0;
                  fill   <= '0;
               end
            endcase
         end
      end
   end

`ifdef PRBS_CHK_BITCNT_EN
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         bit_cnt <= '0;
      end else if (in_valid && state == LOCKED) begin
         bit_cnt <= bit_cnt + 32'd1;
      end
   end
`else
   assign bit_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs_chk.sv
// Directed bench for prbs_chk: an 8-bit generator model (x^8+x^4+x^3+x^2+1, seed 8'hFF) drives the checker.
// Expected lock points, error counts and window behaviour are hand-derived constants.
module tb_prbs_chk;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_bit;
   logic        clr;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_cnt;
   logic [31:0] bit_cnt;

   int checks   = 0;
   int failures = 0;
   logic [7:0] gen_sr;

`ifdef PRBS_CHK_BITCNT_EN
   localparam bit BITCNT_EN = 1'b1;
`else
   localparam bit BITCNT_EN = 1'b0;
`endif

   prbs_chk dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .clr       (clr),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt),
      .bit_cnt   (bit_cnt)
   );

   always #5 clk = ~clk;

   // Generator: output sr[0], feedback taps sr[0],sr[4],sr[5],sr[6] (POLY bits 7,3,2,1).
   task automatic gen(output logic b);
      b = gen_sr[0];
      gen_sr = {gen_sr[0] ^ gen_sr[4] ^ gen_sr[5] ^ gen_sr[6], gen_sr[7:1]};
   endtask

   // Drive one cycle; outputs are observed 1 time unit after the edge.
   task automatic step(input logic v, input logic b);
      in_valid = v;
      in_bit   = b;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      gen_sr = 8'hFF;
   endtask

   task automatic lock_up();
      logic b;
      for (int i = 0; i < 24; i++) begin
         gen(b);
         step(1'b1, b);
      end
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL lock_up: locked=%0b expected 1", locked);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; clr = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %0b expected 0", locked); end
      checks++;
      if (err_pulse !== 1'b0) begin failures++; $display("FAIL reset_err_pulse: got %0b expected 0", err_pulse); end
      checks++;
      if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
      checks++;
      if (bit_cnt !== 32'd0) begin failures++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
   endtask

   task automatic test_clean_lock();
      logic b;
      int first_lock = 0, drops = 0, pulses = 0;
      do_reset();
      for (int i = 1; i <= 1000; i++) begin
         gen(b);
         step(1'b1, b);
         if (locked === 1'b1 && first_lock == 0) first_lock = i;
         if (first_lock != 0 && locked !== 1'b1) drops++;
         if (err_pulse !== 1'b0) pulses++;
      end
      checks++;
      if (first_lock != 24) begin failures++; $display("FAIL clean_first_lock: bit %0d expected 24", first_lock); end
      checks++;
      if (drops != 0) begin failures++; $display("FAIL clean_drops: got %0d expected 0", drops); end
      checks++;
      if (pulses != 0) begin failures++; $display("FAIL clean_pulses: got %0d expected 0", pulses); end
      checks++;
      if (err_cnt !== 16'd0) begin failures++; $display("FAIL clean_err_cnt: got %0d expected 0", err_cnt); end
      checks++;
      if (bit_cnt !== (BITCNT_EN ? 32'd976 : 32'd0)) begin
         failures++;
         $display("FAIL clean_bit_cnt: got %0d expected %0d", bit_cnt, BITCNT_EN ? 976 : 0);
      end
   endtask

   task automatic test_single_error();
      logic b;
      int pulses = 0, pulse_at = 0, drops = 0;
      do_reset();
      lock_up();
      for (int j = 1; j <= 300; j++) begin
         gen(b);
         if (j == 100) b = ~b;
         step(1'b1, b);
         if (err_pulse === 1'b1) begin pulses++; pulse_at = j; end
         if (locked !== 1'b1) drops++;
      end
      checks++;
      if (pulse_at != 100) begin failures++; $display("FAIL single_pulse_at: bit %0d expected 100", pulse_at); end
      checks++;
      if (pulses != 1) begin failures++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
      checks++;
      if (err_cnt !== 16'd1) begin failures++; $display("FAIL single_err_cnt: got %0d expected 1", err_cnt); end
      checks++;
      if (drops != 0) begin failures++; $display("FAIL single_drops: got %0d expected 0", drops); end
   endtask

   task automatic test_burst_unlock();
      logic b;
      do_reset();
      lock_up();
      for (int j = 1; j <= 40; j++) begin
         gen(b);
         if (j % 10 == 0) b = ~b;
         step(1'b1, b);
         if (j == 39) begin
            checks++;
            if (locked !== 1'b1) begin failures++; $display("FAIL burst_before_4th: locked=%0b expected 1", locked); end
         end
      end
      checks++;
      if (locked !== 1'b0) begin failures++; $display("FAIL burst_unlock: locked=%0b expected 0", locked); end
      checks++;
      if (err_pulse !== 1'b1) begin failures++; $display("FAIL burst_pulse: got %0b expected 1", err_pulse); end
      checks++;
      if (err_cnt !== 16'd4) begin failures++; $display("FAIL burst_err_cnt: got %0d expected 4", err_cnt); end
      for (int n = 1; n <= 24; n++) begin
         gen(b);
         step(1'b1, b);
         if (n == 23) begin
            checks++;
            if (locked !== 1'b0) begin failures++; $display("FAIL burst_relock_early: locked=%0b expected 0", locked); end
         end
      end
      checks++;
      if (locked !== 1'b1) begin failures++; $display("FAIL burst_relock: locked=%0b expected 1", locked); end
      checks++;
      if (err_cnt !== 16'd4) begin failures++; $display("FAIL burst_err_persist: got %0d expected 4", err_cnt); end
   endtask

   task automatic test_two_windows();
      logic b;
      int drops = 0;
      do_reset();
      lock_up();
      // Locked-bit indices 61..63 close window 0, 64..66 open window 1.
      for (int j = 1; j <= 150; j++) begin
         gen(b);
         if (j >= 62 && j <= 67) b = ~b;
         step(1'b1, b);
         if (locked !== 1'b1) drops++;
      end
      checks++;
      if (drops != 0) begin failures++; $display("FAIL window_drops: got %0d expected 0", drops); end
      checks++;
      if (err_cnt !== 16'd6) begin failures++; $display("FAIL window_err_cnt: got %0d expected 6", err_cnt); end
   endtask

   task automatic test_zero_stream();
      int ever = 0, pulses = 0;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         step(1'b1, 1'b0);
         if (locked !== 1'b0) ever++;
         if (err_pulse !== 1'b0) pulses++;
      end
      checks++;
      if (ever != 0) begin failures++; $display("FAIL zero_locked: got %0d cycles expected 0", ever); end
      checks++;
      if (pulses != 0) begin failures++; $display("FAIL zero_pulses: got %0d expected 0", pulses); end
      checks++;
      if (err_cnt !== 16'd0) begin failures++; $display("FAIL zero_err_cnt: got %0d expected 0", err_cnt); end
   endtask

   task automatic test_verify_mismatch();
      logic b;
      int first_lock = 0;
      do_reset();
      for (int i = 1; i <= 60; i++) begin
         gen(b);
         if (i == 15) b = ~b;
         step(1'b1, b);
         if (locked === 1'b1 && first_lock == 0) first_lock = i;
      end
      checks++;
      if (first_lock != 39) begin failures++; $display("FAIL verify_relock: bit %0d expected 39", first_lock); end
      checks++;
      if (err_cnt !== 16'd0) begin failures++; $display("FAIL verify_err_cnt: got %0d expected 0", err_cnt); end
   endtask

   task automatic test_gapped();
      logic b;
      logic v;
      int first_lock = 0, drops = 0, pulses = 0;
      do_reset();
      for (int i = 1; i <= 80; i++) begin
         v = (i % 2 == 1);
         if (v) gen(b);
         else b = 1'($urandom_range(0, 1));
         step(v, b);
         if (locked === 1'b1 && first_lock == 0) first_lock = i;
         if (first_lock != 0 && locked !== 1'b1) drops++;
         if (err_pulse !== 1'b0) pulses++;
      end
      checks++;
      if (first_lock != 47) begin failures++; $display("FAIL gapped_first_lock: cycle %0d expected 47", first_lock); end
      checks++;
      if (drops != 0) begin failures++; $display("FAIL gapped_drops: got %0d expected 0", drops); end
      checks++;
      if (pulses != 0) begin failures++; $display("FAIL gapped_pulses: got %0d expected 0", pulses); end
   endtask

   task automatic test_rst_while_locked();
      logic b;
      do_reset();
      lock_up();
      for (int j = 1; j <= 90; j++) begin
         gen(b);
         if (j == 10 || j == 20 || j == 30 || j == 70 || j == 80) b = ~b;
         step(1'b1, b);
      end
      checks++;
      if (locked !== 1'b1 || err_cnt !== 16'd5) begin
         failures++;
         $display("FAIL pre_rst_state: locked=%0b err_cnt=%0d expected 1 and 5", locked, err_cnt);
      end
      gen(b);
      rst = 1'b1;
      step(1'b1, ~b);
      rst = 1'b0;
      checks++;
      if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked: got %0b expected 0", locked); end
      checks++;
      if (err_pulse !== 1'b0) begin failures++; $display("FAIL rst_err_pulse: got %0b expected 0", err_pulse); end
      checks++;
      if (err_cnt !== 16'd0) begin failures++; $display("FAIL rst_err_cnt: got %0d expected 0", err_cnt); end
      checks++;
      if (bit_cnt !== 32'd0) begin failures++; $display("FAIL rst_bit_cnt: got %0d expected 0", bit_cnt); end
   endtask

   task automatic test_clr();
      logic b;
      do_reset();
      lock_up();
      for (int j = 1; j <= 20; j++) begin
         gen(b);
         if (j == 5 || j == 10) b = ~b;
         step(1'b1, b);
      end
      checks++;
      if (err_cnt !== 16'd2) begin failures++; $display("FAIL pre_clr_err_cnt: got %0d expected 2", err_cnt); end
      gen(b);
      clr = 1'b1;
      step(1'b1, ~b);
      clr = 1'b0;
      checks++;
      if (err_pulse !== 1'b1) begin failures++; $display("FAIL clr_err_pulse: got %0b expected 1", err_pulse); end
      checks++;
      if (err_cnt !== 16'd0) begin failures++; $display("FAIL clr_err_cnt: got %0d expected 0", err_cnt); end
      for (int j = 0; j < 10; j++) begin
         gen(b);
         step(1'b1, b);
      end
      checks++;
      if (bit_cnt !== (BITCNT_EN ? 32'd10 : 32'd0)) begin
         failures++;
         $display("FAIL clr_bit_cnt: got %0d expected %0d", bit_cnt, BITCNT_EN ? 10 : 0);
      end
      checks++;
      if (locked !== 1'b1 || err_cnt !== 16'd0) begin
         failures++;
         $display("FAIL post_clr_state: locked=%0b err_cnt=%0d expected 1 and 0", locked, err_cnt);
      end
   endtask

   initial begin
      gen_sr = 8'hFF;
      test_reset();
      test_clean_lock();
      test_single_error();
      test_burst_unlock();
      test_two_windows();
      test_zero_stream();
      test_verify_mismatch();
      test_gapped();
      test_rst_while_locked();
      test_clr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
